// File: rtl/fit_scheduler_if.sv
// Signal bundle between the game controller, the fit scheduler and the shared fit checker.
// master is the scheduler side; slave is the controller/checker side.
interface fit_scheduler_if;
  logic       enable;
  logic [3:0] level;
  logic       req_left;
  logic       req_right;
  logic       req_down;
  logic       req_rotate;
  logic       spawn_done;
  logic       chk_done;
  logic       chk_fit;
  logic       chk_valid;
  logic [1:0] chk_dx;
  logic       chk_dy;
  logic       chk_rot;
  logic       move_commit;
  logic [1:0] move_dx;
  logic       move_dy;
  logic       move_rot;
  logic       lock_piece;
  logic       busy;
  logic       wd_err;

  modport master (
    input  enable, level, req_left, req_right, req_down, req_rotate, spawn_done,
    input  chk_done, chk_fit,
    output chk_valid, chk_dx, chk_dy, chk_rot,
    output move_commit, move_dx, move_dy, move_rot, lock_piece, busy, wd_err
  );

  modport slave (
    output enable, level, req_left, req_right, req_down, req_rotate, spawn_done,
    output chk_done, chk_fit,
    input  chk_valid, chk_dx, chk_dy, chk_rot,
    input  move_commit, move_dx, move_dy, move_rot, lock_piece, busy, wd_err
  );
endinterface

// File: rtl/fit_scheduler.sv
// Arbitrates gravity and key requests onto one shared fit checker and turns the answers
// into piece moves, locks, and a sticky checker-timeout flag.
module fit_scheduler #(
  parameter int unsigned TICK_DIV = 6250000,
  parameter int unsigned WD_MAX   = 15
) (
  input logic             clk,
  input logic             rst,
  fit_scheduler_if.master bus_io
);

  localparam int unsigned CntW  = $clog2(16 * TICK_DIV);
  localparam int unsigned WdW   = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;
  localparam int unsigned BGrav = 0;
  localparam int unsigned BRot  = 1;
  localparam int unsigned BLeft = 2;
  localparam int unsigned BRght = 3;
  localparam int unsigned BDown = 4;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResolve, StLockWait} state_e;

  state_e          state_q, state_d;
  logic [4:0]      pend_q, pend_d;
  logic [4:0]      grant_q, grant_d;
  logic [4:0]      pick, req_vec;
  logic            fit_q, fit_d;
  logic            wd_err_q, wd_err_d;
  logic [CntW-1:0] cnt_q, cnt_d, limit;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            run_cnt, tick;
  logic [1:0]      off_dx;
  logic            off_dy, off_rot;

  // Recomputed every cycle so a level change takes effect at the next compare.
  assign limit   = CntW'((32'd16 - 32'(bus_io.level)) * TICK_DIV - 32'd1);
  assign run_cnt = bus_io.enable && (state_q != StLockWait);
  assign tick    = run_cnt && (cnt_q >= limit);
  assign req_vec = {bus_io.req_down, bus_io.req_right, bus_io.req_left, bus_io.req_rotate, tick};

  always_comb begin
    pick = '0;
    if (pend_q[BGrav])      pick[BGrav] = 1'b1;
    else if (pend_q[BRot])  pick[BRot]  = 1'b1;
    else if (pend_q[BLeft]) pick[BLeft] = 1'b1;
    else if (pend_q[BRght]) pick[BRght] = 1'b1;
    else if (pend_q[BDown]) pick[BDown] = 1'b1;
  end

  assign off_dx  = grant_q[BLeft] ? 2'b11 : (grant_q[BRght] ? 2'b01 : 2'b00);
  assign off_dy  = grant_q[BGrav] | grant_q[BDown];
  assign off_rot = grant_q[BRot];

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    grant_d  = grant_q;
    fit_d    = fit_q;
    wd_d     = wd_q;
    wd_err_d = wd_err_q;
    cnt_d    = cnt_q;

    bus_io.chk_valid   = 1'b0;
    bus_io.chk_dx      = 2'b00;
    bus_io.chk_dy      = 1'b0;
    bus_io.chk_rot     = 1'b0;
    bus_io.move_commit = 1'b0;
    bus_io.move_dx     = 2'b00;
    bus_io.move_dy     = 1'b0;
    bus_io.move_rot    = 1'b0;
    bus_io.lock_piece  = 1'b0;
    bus_io.busy        = (state_q != StIdle);
    bus_io.wd_err      = wd_err_q;

    if (run_cnt) begin
      cnt_d  = tick ? '0 : cnt_q + CntW'(1);
      pend_d = pend_q | req_vec;
    end

    case (state_q)
      StIdle: begin
        if (bus_io.enable && (pend_q != '0)) begin
          grant_d = pick;
          pend_d  = pend_d & ~pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        bus_io.chk_valid = 1'b1;
        bus_io.chk_dx    = off_dx;
        bus_io.chk_dy    = off_dy;
        bus_io.chk_rot   = off_rot;
        wd_d             = '0;
        state_d          = StWait;
      end
      StWait: begin
        if (bus_io.chk_done) begin
          fit_d   = bus_io.chk_fit;
          state_d = StResolve;
        end else if (wd_q == WdW'(WD_MAX - 1)) begin
          fit_d    = 1'b0;
          wd_err_d = 1'b1;
          state_d  = StResolve;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResolve: begin
        if (fit_q) begin
          bus_io.move_commit = 1'b1;
          bus_io.move_dx     = off_dx;
          bus_io.move_dy     = off_dy;
          bus_io.move_rot    = off_rot;
          state_d            = StIdle;
        end else if (grant_q[BGrav]) begin
          bus_io.lock_piece = 1'b1;
          pend_d            = '0;
          cnt_d             = '0;
          state_d           = StLockWait;
        end else begin
          state_d = StIdle;
        end
      end
      StLockWait: begin
        if (bus_io.spawn_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      grant_q  <= '0;
      fit_q    <= 1'b0;
      wd_q     <= '0;
      wd_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      grant_q  <= grant_d;
      fit_q    <= fit_d;
      wd_q     <= wd_d;
      wd_err_q <= wd_err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
